// File: rtl/skyline_layer.sv
// Per-pixel skyline layer classifier: LFSR-driven column heights, per-line
// cutoff from the line number, and a per-frame horizontal scroll offset.
module skyline_layer #(
  parameter int       COL_SHIFT  = 3,
  parameter int       ROW_SHIFT  = 4,
  parameter int       BASE_LINE  = 112,
  parameter bit [8:0] LFSR_SEED  = 9'h1FF,
  parameter int       SCROLL_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_start,
  input  logic       frame_start,
  input  logic       pix_en,
  input  logic [9:0] vcount,
  output logic       px_valid,
  output logic [1:0] px_layer
);

  localparam logic [9:0]           BASE_L    = 10'(BASE_LINE);
  localparam logic [7:0]           PRESC_TOP = 8'(SCROLL_DIV - 1);
  localparam logic [COL_SHIFT-1:0] COL_ONE   = COL_SHIFT'(1);

  logic [8:0]           lfsr_q, lfsr_d;
  logic [8:0]           lfsr_base_q, lfsr_base_d;
  logic [COL_SHIFT-1:0] col_cnt_q, col_cnt_d;
  logic [COL_SHIFT-1:0] cnt_base_q, cnt_base_d;
  logic [7:0]           presc_q, presc_d;
  logic [4:0]           cutoff_q, cutoff_d;
  logic                 row_edge_q, row_edge_d;
  logic                 px_valid_q, px_valid_d;
  logic [1:0]           px_layer_q, px_layer_d;

  logic [9:0] line_off;
  logic [9:0] row_idx;
  logic [4:0] cutoff_calc;
  logic       row_edge_calc;
  logic       building;
  logic       edge_px;

  function automatic logic [8:0] lfsr_step(input logic [8:0] l);
    return {l[7:0], l[8] ^ l[4]};
  endfunction

  // Line geometry: height steps above BASE_LINE, saturated at the full 16-step height.
  always_comb begin
    line_off      = vcount - BASE_L;
    row_idx       = line_off >> ROW_SHIFT;
    cutoff_calc   = (row_idx >= 10'd16) ? 5'd16 : (row_idx[4:0] + 5'd1);
    row_edge_calc = (line_off[ROW_SHIFT-1:0] == '0) || (&line_off[ROW_SHIFT-1:0]);
  end

  always_comb begin
    building = ({1'b0, lfsr_q[3:0]} < cutoff_q);
    edge_px  = building && (row_edge_q || (col_cnt_q == '0) || (col_cnt_q == COL_ONE));
  end

  always_comb begin
    lfsr_d      = lfsr_q;
    lfsr_base_d = lfsr_base_q;
    col_cnt_d   = col_cnt_q;
    cnt_base_d  = cnt_base_q;
    presc_d     = presc_q;
    cutoff_d    = cutoff_q;
    row_edge_d  = row_edge_q;
    px_valid_d  = pix_en;
    px_layer_d  = 2'd0;

    if (frame_start) begin
      if (presc_q == PRESC_TOP) begin
        presc_d    = 8'd0;
        cnt_base_d = cnt_base_q + COL_ONE;
        if (&cnt_base_q) begin
          lfsr_base_d = lfsr_step(lfsr_base_q);
        end
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end

    // Line reload reads the base registers before any same-cycle frame update.
    if (line_start) begin
      lfsr_d    = lfsr_base_q;
      col_cnt_d = cnt_base_q;
      if (vcount < BASE_L) begin
        cutoff_d   = 5'd0;
        row_edge_d = 1'b0;
      end else begin
        cutoff_d   = cutoff_calc;
        row_edge_d = row_edge_calc;
      end
    end else if (pix_en) begin
      px_layer_d = edge_px ? 2'd2 : (building ? 2'd1 : 2'd0);
      col_cnt_d  = col_cnt_q + COL_ONE;
      if (&col_cnt_q) begin
        lfsr_d = lfsr_step(lfsr_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q      <= LFSR_SEED;
      lfsr_base_q <= LFSR_SEED;
      col_cnt_q   <= '0;
      cnt_base_q  <= '0;
      presc_q     <= 8'd0;
      cutoff_q    <= 5'd0;
      row_edge_q  <= 1'b0;
      px_valid_q  <= 1'b0;
      px_layer_q  <= 2'd0;
    end else begin
      lfsr_q      <= lfsr_d;
      lfsr_base_q <= lfsr_base_d;
      col_cnt_q   <= col_cnt_d;
      cnt_base_q  <= cnt_base_d;
      presc_q     <= presc_d;
      cutoff_q    <= cutoff_d;
      row_edge_q  <= row_edge_d;
      px_valid_q  <= px_valid_d;
      px_layer_q  <= px_layer_d;
    end
  end

  assign px_valid = px_valid_q;
  assign px_layer = px_layer_q;

endmodule
